mic1_exec_ctrl: RTL
===================

Name: mic1_exec_ctrl

Overview:
Execution controller that sequences the MIC-1 datapath from the front-panel buttons. It takes debounced button levels and datapath status (MPC, halt), and produces the datapath clock-enable (one pulse per microinstruction) and a multi-cycle synchronous datapath reset. It supports run, single-step, stop, halt and a single MPC breakpoint. It sits between the button debouncers and the MIC-1 core, and drives the status LEDs.

Parameters:
MPC_W, 9, width of MPC and breakpoint address
RUN_DIV, 4, clk cycles per microstep in RUN (≥1)
RST_CYCLES, 4, cycles mic1_rst held after reset request (≥1)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
btn_run  in  1  debounced level, run request
btn_step  in  1  debounced level, single-step request
btn_stop  in  1  debounced level, stop request
btn_reset  in  1  debounced level, datapath reset request
mic1_halt  in  1  datapath executed HALT (level)
mpc  in  MPC_W  current datapath MPC
bp_en  in  1  breakpoint enable
bp_addr  in  MPC_W  breakpoint MPC
mic1_ce  out  1  datapath clock enable, 1-cycle pulse per microstep
mic1_rst  out  1  synchronous datapath reset
led_idle  out  1  state==IDLE
led_run_status  out  1  state==RUN or STEP
led_halt  out  1  state==HALTED
led_run_step  out  4  microstep count mod 16
bp_hit  out  1  sticky, breakpoint stopped RUN

Behaviour:
- States: RST_SEQ, IDLE, RUN, STEP, HALTED (enum in package).
- Async reset: state=RST_SEQ, rst_cnt=RST_CYCLES-1, div_cnt=0, step_cnt=0, bp_hit=0, bp_skip=0, edge-detect regs=1. mic1_rst=1; all other outputs 0.
- Edge detect: each btn_* is registered; pulse = btn & ~btn_q. Reset value 1, so a button held through reset release gives no pulse. A held button yields exactly one pulse.
- Pulse priority in the same cycle: reset > stop > step > run. Only the highest-priority pulse is acted on.
- reset pulse in any state: RST_SEQ, rst_cnt reloaded. A reset pulse during RST_SEQ restarts the count.
- RST_SEQ: mic1_rst=1. rst_cnt decrements; at 0, go to IDLE. Total mic1_rst high = RST_CYCLES cycles after the entry edge. On exit: step_cnt=0, bp_hit=0, div_cnt=0.
- IDLE: run pulse → RUN with bp_skip=1, div_cnt=0, bp_hit=0. step pulse → STEP with bp_hit=0. stop is ignored.
- RUN:
  - div_cnt counts 0..RUN_DIV-1 and wraps.
  - mic1_ce = (div_cnt==RUN_DIV-1) & ~mic1_halt & ~(bp_match & ~bp_skip), where bp_match = bp_en & (mpc==bp_addr).
  - On each issued ce, bp_skip clears. The first microstep after resume therefore executes even if MPC sits on the breakpoint.
  - bp_match & ~bp_skip → IDLE, bp_hit=1, no ce that cycle.
  - mic1_halt → HALTED, no ce that cycle.
  - stop pulse → IDLE. A ce coinciding with the stop cycle is still issued.
  - Precedence: reset > halt > breakpoint > stop.
- STEP: exactly one cycle with mic1_ce=1 regardless of bp/halt, then → IDLE. The step_cnt increment is the only side effect.
- HALTED: mic1_ce=0. Only a reset pulse exits; run and step are ignored.
- step_cnt: 4-bit, increments on every cycle with mic1_ce=1 and wraps 15→0. led_run_step = step_cnt.
- Outputs led_* decode the registered state only (no input-to-LED combinational path). mic1_ce is combinational from registers plus mic1_halt/mpc/bp gating.
- Widths: mpc comparison is exact MPC_W bits. div_cnt width = $clog2(RUN_DIV) (min 1).

Decomposition:
- Package mic1_ctrl_pkg holds:
  - the exec_state_t enum (RST_SEQ, IDLE, RUN, STEP, HALTED)
  - localparam CNT_W=4
  - the default MPC_W.
- One sub-module: btn_edge_det (registered rising-edge pulse, reset value 1, parameterised width), instantiated once for the 4 buttons.

Test Plan:
1. Release resetn, all buttons 0 → mic1_rst high for 4 cycles, then led_idle=1, led_run_step=0, mic1_ce=0.
2. Pulse btn_step 3 times (separate presses) → exactly 3 one-cycle mic1_ce pulses, led_run_step=3, back to IDLE after each.
3. btn_run held for 20 cycles → ce every 4th cycle (5 pulses). Then btn_stop → led_idle=1, no further ce. Holding btn_run produces only one RUN entry.
4. bp_en=1, bp_addr=9'h005, RUN, mpc reaches 0x005 → no ce that cycle, bp_hit=1, led_idle=1. Then press run → next ce is issued at mpc=0x005 and bp_hit clears.
5. In RUN, assert mic1_halt → led_halt=1, ce stops. btn_step and btn_run are ignored. btn_reset → 4-cycle mic1_rst, then IDLE with led_run_step=0.
6. Same cycle btn_stop and btn_run rising while IDLE, and btn_reset with btn_step while RUN → stop wins (stay IDLE), and reset wins (RST_SEQ). resetn low mid-RUN → immediate mic1_ce=0, mic1_rst=1.

Source files
------------

// File: rtl/mic1_ctrl_pkg.sv
// Shared types and constants for the MIC-1 execution controller.
package mic1_ctrl_pkg;

  localparam int CNT_W     = 4;
  localparam int MPC_W_DEF = 9;

  typedef enum logic [2:0] {
    RST_SEQ,
    IDLE,
    RUN,
    STEP,
    HALTED
  } exec_state_t;

endpackage

// File: rtl/btn_edge_det.sv
// Registered rising-edge detector; resets high so a button held through reset never pulses.
module btn_edge_det #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] btn,
  output logic [WIDTH-1:0] pulse
);

  logic [WIDTH-1:0] btn_p0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) btn_p0 <= '1;
    else         btn_p0 <= btn;
  end

  assign pulse = btn & ~btn_p0;

endmodule

// File: rtl/mic1_exec_ctrl.sv
// Front-panel execution controller for the MIC-1 datapath: run/step/stop/halt,
// MPC breakpoint, datapath clock-enable pulses and a multi-cycle datapath reset.
module mic1_exec_ctrl
  import mic1_ctrl_pkg::*;
#(
  parameter int MPC_W      = MPC_W_DEF,
  parameter int RUN_DIV    = 4,
  parameter int RST_CYCLES = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             btn_run,
  input  logic             btn_step,
  input  logic             btn_stop,
  input  logic             btn_reset,
  input  logic             mic1_halt,
  input  logic [MPC_W-1:0] mpc,
  input  logic             bp_en,
  input  logic [MPC_W-1:0] bp_addr,
  output logic             mic1_ce,
  output logic             mic1_rst,
  output logic             led_idle,
  output logic             led_run_status,
  output logic             led_halt,
  output logic [3:0]       led_run_step,
  output logic             bp_hit
);

  localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam int RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
  localparam logic [RC_W-1:0]  RC_LOAD  = RC_W'(RST_CYCLES - 1);

  exec_state_t      state, state_nxt;
  logic [RC_W-1:0]  rst_cnt, rst_cnt_nxt;
  logic [DIV_W-1:0] div_cnt, div_cnt_nxt;
  logic [CNT_W-1:0] step_cnt, step_cnt_nxt;
  logic             bp_hit_nxt;
  logic             bp_skip, bp_skip_nxt;
  logic             ce;

  logic [3:0] pulse;
  logic       rst_p, stop_p, step_p, run_p;
  logic       bp_match, bp_stop;

  btn_edge_det #(.WIDTH(4)) u_edge (
    .clk    (clk),
    .resetn (resetn),
    .btn    ({btn_reset, btn_stop, btn_step, btn_run}),
    .pulse  (pulse)
  );

  // Only the highest-priority pulse in a cycle survives.
  assign rst_p  = pulse[3];
  assign stop_p = pulse[2] & ~pulse[3];
  assign step_p = pulse[1] & ~(|pulse[3:2]);
  assign run_p  = pulse[0] & ~(|pulse[3:1]);

  assign bp_match = bp_en & (mpc == bp_addr);
  assign bp_stop  = bp_match & ~bp_skip;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= RST_SEQ;
      rst_cnt  <= RC_LOAD;
      div_cnt  <= '0;
      step_cnt <= '0;
      bp_hit   <= 1'b0;
      bp_skip  <= 1'b0;
    end else begin
      state    <= state_nxt;
      rst_cnt  <= rst_cnt_nxt;
      div_cnt  <= div_cnt_nxt;
      step_cnt <= step_cnt_nxt;
      bp_hit   <= bp_hit_nxt;
      bp_skip  <= bp_skip_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    rst_cnt_nxt  = rst_cnt;
    div_cnt_nxt  = div_cnt;
    step_cnt_nxt = step_cnt;
    bp_hit_nxt   = bp_hit;
    bp_skip_nxt  = bp_skip;
    ce           = 1'b0;

    case (state)
      RST_SEQ: begin
        if (rst_cnt == '0) begin
          state_nxt    = IDLE;
          step_cnt_nxt = '0;
          bp_hit_nxt   = 1'b0;
          div_cnt_nxt  = '0;
        end else begin
          rst_cnt_nxt = rst_cnt - RC_W'(1);
        end
      end
      IDLE: begin
        if (run_p) begin
          state_nxt   = RUN;
          bp_skip_nxt = 1'b1;
          div_cnt_nxt = '0;
          bp_hit_nxt  = 1'b0;
        end else if (step_p) begin
          state_nxt  = STEP;
          bp_hit_nxt = 1'b0;
        end
      end
      RUN: begin
        div_cnt_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
        ce = (div_cnt == DIV_LAST) & ~mic1_halt & ~bp_stop;
        // The first microstep after resume clears the skip, re-arming the breakpoint.
        if (ce) bp_skip_nxt = 1'b0;
        if (mic1_halt) begin
          state_nxt = HALTED;
        end else if (bp_stop) begin
          state_nxt  = IDLE;
          bp_hit_nxt = 1'b1;
        end else if (stop_p) begin
          state_nxt = IDLE;
        end
      end
      STEP: begin
        ce        = 1'b1;
        state_nxt = IDLE;
      end
      HALTED: begin
        state_nxt = HALTED;
      end
      default: begin
        state_nxt = RST_SEQ;
      end
    endcase

    if (ce) step_cnt_nxt = step_cnt + CNT_W'(1);

    // Reset request overrides everything and restarts the reset sequence.
    if (rst_p) begin
      state_nxt   = RST_SEQ;
      rst_cnt_nxt = RC_LOAD;
    end
  end

  assign mic1_ce        = ce;
  assign mic1_rst       = (state == RST_SEQ);
  assign led_idle       = (state == IDLE);
  assign led_run_status = (state == RUN) || (state == STEP);
  assign led_halt       = (state == HALTED);
  assign led_run_step   = step_cnt;

endmodule
